// File: rtl/branch_predictor_bht.sv
// Fetch-stage bimodal branch predictor with a registered misprediction recovery FSM.
// Optional gshare indexing is enabled by defining GSHARE_EN.
module branch_predictor_bht #(
    parameter int PC_SIZE      = 12,
    parameter int INDEX_BITS   = 6,
    parameter int CTR_BITS     = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [6:0]         opcode,
    input  logic [PC_SIZE-1:0] current_pc,
    input  logic [PC_SIZE-1:0] next_consecutive_pc,
    input  logic [PC_SIZE-1:0] jump_pc,
    output logic               predict_taken,
    output logic [PC_SIZE-1:0] next_pc,
    input  logic               resolve_valid,
    input  logic               resolve_is_branch,
    input  logic [PC_SIZE-1:0] resolve_pc,
    input  logic               resolve_taken,
    input  logic               resolve_predicted,
    input  logic [PC_SIZE-1:0] resolve_target,
    input  logic [PC_SIZE-1:0] resolve_fallthrough,
    output logic               redirect_valid,
    output logic [PC_SIZE-1:0] redirect_pc,
    output logic               force_nop
);

    localparam logic [6:0] J_FORMAT = 7'b1101111;
    localparam logic [6:0] B_FORMAT = 7'b1100011;

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic                  redirect_valid_d;
    logic [PC_SIZE-1:0]    redirect_pc_d;
    logic                  force_nop_d;

    logic [CTR_BITS-1:0]   ctr [DEPTH];
    logic [INDEX_BITS-1:0] fetch_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic                  table_update;
    logic                  mispredict;

    // Upper PC bits only matter for targets, never for indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{current_pc[PC_SIZE-1:INDEX_BITS], resolve_pc[PC_SIZE-1:INDEX_BITS]};

`ifdef GSHARE_EN
    logic [INDEX_BITS-1:0] ghr;

    assign fetch_idx = current_pc[INDEX_BITS-1:0] ^ ghr;
    assign upd_idx   = resolve_pc[INDEX_BITS-1:0] ^ ghr;

    // History advances only with resolved branches, so it never needs repair on a flush.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ghr <= '0;
        end else if (table_update) begin
            ghr <= {ghr[INDEX_BITS-2:0], resolve_taken};
        end
    end
`else
    assign fetch_idx = current_pc[INDEX_BITS-1:0];
    assign upd_idx   = resolve_pc[INDEX_BITS-1:0];
`endif

    assign table_update = resolve_valid & resolve_is_branch & (state_q == IDLE);
    assign mispredict   = resolve_valid & (resolve_taken != resolve_predicted) & (state_q == IDLE);

    assign predict_taken = (opcode == J_FORMAT) |
                           ((opcode == B_FORMAT) & ctr[fetch_idx][CTR_BITS-1]);
    assign next_pc = redirect_valid ? redirect_pc :
                     (predict_taken ? jump_pc : next_consecutive_pc);

    // NOTE: the counter table must come out of reset weakly not-taken, so it is a
    // reset flop array rather than a RAM; a reset-less array would start at X.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= CTR_INIT;
            end
        end else if (table_update) begin
            if (resolve_taken && (ctr[upd_idx] != CTR_MAX)) begin
                ctr[upd_idx] <= ctr[upd_idx] + CTR_BITS'(1);
            end else if (!resolve_taken && (ctr[upd_idx] != '0)) begin
                ctr[upd_idx] <= ctr[upd_idx] - CTR_BITS'(1);
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc;
        force_nop_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d          = FLUSH;
                    flush_cnt_d      = CNT_LOAD;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = resolve_taken ? resolve_target : resolve_fallthrough;
                    force_nop_d      = 1'b1;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                    force_nop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= IDLE;
            flush_cnt_q    <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            force_nop      <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            force_nop      <= force_nop_d;
        end
    end

endmodule
